// File: rtl/control_seq_pkg.sv
// Shared types for the control sequencer: FSM states, instruction classes and class decode.
// CONTROL_SEQ_IRQ_EN adds the IRQ state.
package control_seq_pkg;

`ifdef CONTROL_SEQ_IRQ_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IRQ   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1
    } state_t;
`endif

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_RSV = 2'd2,
        CLS_JMP = 2'd3
    } cls_t;

    // Top three IR bits select the class: 0xx ALU, 10x MEM, 110 reserved, 111 JMP.
    function automatic cls_t class_of(input logic [2:0] code);
        cls_t c;
        casez (code)
            3'b0??:  c = CLS_ALU;
            3'b10?:  c = CLS_MEM;
            3'b110:  c = CLS_RSV;
            3'b111:  c = CLS_JMP;
            default: c = CLS_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_seq_decode.sv
// Combinational strobe decode from IR, EXEC cycle index and carry flag.
// All strobes and field passthroughs are zero outside EXEC (J is forced high in the IRQ cycle).
module control_seq_decode
    import control_seq_pkg::*;
#(
    parameter int IW    = 8,
    parameter int ALU_W = 4,
    parameter int RS_W  = 2,
    parameter int CYC_W = 2
) (
    input  logic              in_exec,
    input  logic              in_irq,
    input  logic [IW-1:0]     ir,
    input  logic [CYC_W-1:0]  cycle,
    input  logic              carry_q,
    output cls_t              cls,
    output logic              mc,
    output logic              m,
    output logic              j,
    output logic              s,
    output logic              y,
    output logic [RS_W-1:0]   rs,
    output logic [ALU_W-1:0]  alu
);

    assign cls = class_of(ir[IW-1:IW-3]);

    // Strobe generation; memory address phase is always cycle 0, data phase the rest.
    always_comb begin
        mc  = 1'b0;
        m   = 1'b0;
        j   = 1'b0;
        s   = 1'b0;
        y   = 1'b0;
        rs  = {RS_W{1'b0}};
        alu = {ALU_W{1'b0}};
        if (in_exec) begin
            s   = ir[IW-4];
            y   = ir[IW-3];
            rs  = ir[RS_W-1:0];
            alu = ir[ALU_W-1:0];
            case (cls)
                CLS_MEM: begin
                    if (cycle == {CYC_W{1'b0}}) begin
                        mc = 1'b1;
                    end else begin
                        m = 1'b1;
                    end
                end
                CLS_JMP: j = ~(ir[IW-4] & carry_q);
                CLS_ALU: j = 1'b0;
                CLS_RSV: j = 1'b0;
                default: j = 1'b0;
            endcase
        end else if (in_irq) begin
            j = 1'b1;
        end else begin
            j = 1'b0;
        end
    end

endmodule

// File: rtl/control_seq.sv
// Sequenced CPU control unit: FSM, instruction register, EXEC cycle counter and carry flag.
// Optional interrupt entry when CONTROL_SEQ_IRQ_EN is defined.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int IW      = 8,
    parameter int ALU_W   = 4,
    parameter int RS_W    = 2,
    parameter int MEM_CYC = 2,
    parameter int CYC_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     inst_in,
    input  logic              inst_valid,
    output logic              inst_ack,
    input  logic              mem_ready,
    input  logic              carry_in,
    output logic              busy,
    output logic [CYC_W-1:0]  cycle,
    output logic              MC,
    output logic              M,
    output logic              J,
    output logic              S,
    output logic              Y,
    output logic [RS_W-1:0]   RS,
    output logic [ALU_W-1:0]  ALU,
    output logic              carry_q
`ifdef CONTROL_SEQ_IRQ_EN
    ,
    input  logic              irq,
    output logic              irq_ack
`endif
);

    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MEM_CYC - 1);

    generate
        if (IW < 8 || MEM_CYC < 2 || MEM_CYC > (2 ** CYC_W) - 1) begin : g_bad_param
            $error("control_seq: IW must be >= 8 and MEM_CYC must fit the cycle counter");
        end
    endgenerate

    state_t             state_r, state_s;
    logic [IW-1:0]      ir_r, ir_s;
    logic [CYC_W-1:0]   cycle_r, cycle_s;
    logic               carry_r, carry_s;
    logic               ack_s;
    logic               in_irq_s;
    cls_t               cls_s;
`ifdef CONTROL_SEQ_IRQ_EN
    logic               ie_r, ie_s;

    assign in_irq_s = (state_r == ST_IRQ);
    assign irq_ack  = in_irq_s;
`else
    assign in_irq_s = 1'b0;
`endif

    assign inst_ack = ack_s;
    assign busy     = (state_r != ST_FETCH);
    assign cycle    = cycle_r;
    assign carry_q  = carry_r;

    control_seq_decode #(
        .IW    (IW),
        .ALU_W (ALU_W),
        .RS_W  (RS_W),
        .CYC_W (CYC_W)
    ) u_decode (
        .in_exec (state_r == ST_EXEC),
        .in_irq  (in_irq_s),
        .ir      (ir_r),
        .cycle   (cycle_r),
        .carry_q (carry_r),
        .cls     (cls_s),
        .mc      (MC),
        .m       (M),
        .j       (J),
        .s       (S),
        .y       (Y),
        .rs      (RS),
        .alu     (ALU)
    );

    // Next-state logic; the counter returns to 0 whenever an instruction completes.
    always_comb begin
        state_s = state_r;
        ir_s    = ir_r;
        cycle_s = cycle_r;
        carry_s = carry_r;
        ack_s   = 1'b0;
`ifdef CONTROL_SEQ_IRQ_EN
        ie_s    = ie_r;
`endif
        case (state_r)
            ST_FETCH: begin
`ifdef CONTROL_SEQ_IRQ_EN
                if (irq && ie_r) begin
                    state_s = ST_IRQ;
                end else
`endif
                if (inst_valid) begin
                    ack_s   = 1'b1;
                    ir_s    = inst_in;
                    cycle_s = {CYC_W{1'b0}};
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_ALU: begin
                        carry_s = carry_in;
                        cycle_s = {CYC_W{1'b0}};
                        state_s = ST_FETCH;
                    end
                    CLS_MEM: begin
                        // mem_ready only matters in the data phase; the stall holds the counter.
                        if (cycle_r == {CYC_W{1'b0}}) begin
                            cycle_s = CYC_W'(1);
                        end else if (mem_ready) begin
                            if (cycle_r == LAST_CYC) begin
                                cycle_s = {CYC_W{1'b0}};
                                state_s = ST_FETCH;
                            end else begin
                                cycle_s = cycle_r + CYC_W'(1);
                            end
                        end else begin
                            cycle_s = cycle_r;
                        end
                    end
                    CLS_JMP: begin
                        cycle_s = {CYC_W{1'b0}};
                        state_s = ST_FETCH;
`ifdef CONTROL_SEQ_IRQ_EN
                        if (ir_r[RS_W-1:0] == {RS_W{1'b1}}) begin
                            ie_s = 1'b1;
                        end else begin
                            ie_s = ie_r;
                        end
`endif
                    end
                    CLS_RSV: begin
                        cycle_s = {CYC_W{1'b0}};
                        state_s = ST_FETCH;
                    end
                    default: begin
                        cycle_s = {CYC_W{1'b0}};
                        state_s = ST_FETCH;
                    end
                endcase
            end
`ifdef CONTROL_SEQ_IRQ_EN
            ST_IRQ: begin
                ie_s    = 1'b0;
                state_s = ST_FETCH;
            end
`endif
            default: begin
                cycle_s = {CYC_W{1'b0}};
                state_s = ST_FETCH;
            end
        endcase
    end

    // State, IR, counter and carry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            ir_r    <= {IW{1'b0}};
            cycle_r <= {CYC_W{1'b0}};
            carry_r <= 1'b0;
`ifdef CONTROL_SEQ_IRQ_EN
            ie_r    <= 1'b1;
`endif
        end else begin
            state_r <= state_s;
            ir_r    <= ir_s;
            cycle_r <= cycle_s;
            carry_r <= carry_s;
`ifdef CONTROL_SEQ_IRQ_EN
            ie_r    <= ie_s;
`endif
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Randomized self-checking bench for control_seq against an instruction-level reference model.
// Define CONTROL_SEQ_IRQ_EN to also exercise the interrupt path.
module tb_control_seq;
    localparam int IW      = 8;
    localparam int ALU_W   = 4;
    localparam int RS_W    = 2;
    localparam int MEM_CYC = 3;
    localparam int CYC_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [IW-1:0]     inst_in;
    logic              inst_valid;
    logic              inst_ack;
    logic              mem_ready;
    logic              carry_in;
    logic              busy;
    logic [CYC_W-1:0]  cycle;
    logic              MC, M, J, S, Y;
    logic [RS_W-1:0]   RS;
    logic [ALU_W-1:0]  ALU;
    logic              carry_q;
    logic              irq = 1'b0;
    logic              irq_ack;

    int n_checks = 0;
    int n_pass   = 0;
    logic carry_m = 1'b0;
    logic ie_m    = 1'b1;

    control_seq #(
        .IW(IW), .ALU_W(ALU_W), .RS_W(RS_W), .MEM_CYC(MEM_CYC), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid),
        .inst_ack(inst_ack), .mem_ready(mem_ready), .carry_in(carry_in),
        .busy(busy), .cycle(cycle), .MC(MC), .M(M), .J(J), .S(S), .Y(Y),
        .RS(RS), .ALU(ALU), .carry_q(carry_q)
`ifdef CONTROL_SEQ_IRQ_EN
        , .irq(irq), .irq_ack(irq_ack)
`endif
    );

`ifndef CONTROL_SEQ_IRQ_EN
    assign irq_ack = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every output against explicit expectations, 1 time unit after inputs settle.
    task automatic expect_out(input string tag, input logic b, input logic ack,
                              input logic mc, input logic m, input logic j,
                              input logic s, input logic y, input int rs, input int alu,
                              input int cyc, input logic iack);
        #1;
        check({tag, ".busy"},    busy,     b);
        check({tag, ".ack"},     inst_ack, ack);
        check({tag, ".MC"},      MC,       mc);
        check({tag, ".M"},       M,        m);
        check({tag, ".J"},       J,        j);
        check({tag, ".S"},       S,        s);
        check({tag, ".Y"},       Y,        y);
        check({tag, ".RS"},      RS,       rs);
        check({tag, ".ALU"},     ALU,      alu);
        check({tag, ".cycle"},   cycle,    cyc);
        check({tag, ".carry_q"}, carry_q,  carry_m);
`ifdef CONTROL_SEQ_IRQ_EN
        check({tag, ".irq_ack"}, irq_ack,  iack);
`endif
    endtask

    task automatic expect_idle(input string tag, input logic ack);
        expect_out(tag, 1'b0, ack, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic expect_exec(input string tag, input logic [IW-1:0] ir,
                               input logic mc, input logic m, input logic j, input int cyc);
        expect_out(tag, 1'b1, 1'b0, mc, m, j, ir[IW-4], ir[IW-3],
                   int'(ir % (1 << RS_W)), int'(ir % (1 << ALU_W)), cyc, 1'b0);
    endtask

    // One instruction end to end: idle slots, optional IRQ entry, fetch, then its EXEC cycles.
    // cin_sel 0/1 forces the ALU carry, 2 randomizes it; irq_pct is the chance irq is raised at fetch.
    task automatic run_instr(input logic [IW-1:0] ir, input int idle, input int max_stall,
                             input logic hold_valid, input int cin_sel, input int irq_pct);
        logic [2:0] code;
        logic       cin;
        int         n_stall;
        code = ir[IW-1:IW-3];
        cin  = (cin_sel == 2) ? 1'($urandom) : 1'(cin_sel);
        for (int i = 0; i < idle; i++) begin
            inst_valid = 1'b0; irq = 1'b0;
            inst_in = IW'($urandom); carry_in = 1'($urandom); mem_ready = 1'($urandom);
            expect_idle("idle", 1'b0);
            tick;
        end
        inst_valid = 1'b1; inst_in = ir; carry_in = 1'($urandom); mem_ready = 1'($urandom);
        irq = ($urandom_range(0, 99) < irq_pct);
`ifdef CONTROL_SEQ_IRQ_EN
        if (irq && ie_m) begin
            expect_idle("irq_take", 1'b0);
            tick;
            expect_out("irq_cyc", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
            tick;
            ie_m = 1'b0;
        end
`endif
        expect_idle("fetch", 1'b1);
        tick;
        inst_valid = hold_valid; inst_in = IW'($urandom); mem_ready = 1'($urandom);
        irq = 1'($urandom);
        if (code[2] == 1'b0) begin
            carry_in = cin;
            expect_exec("alu", ir, 1'b0, 1'b0, 1'b0, 0);
            tick;
            carry_m = cin;
        end else if (code == 3'b111) begin
            carry_in = 1'($urandom);
            expect_exec("jmp", ir, 1'b0, 1'b0, ~(ir[IW-4] & carry_m), 0);
            tick;
            if (ir % (1 << RS_W) == (1 << RS_W) - 1) ie_m = 1'b1;
        end else if (code == 3'b110) begin
            carry_in = 1'($urandom);
            expect_exec("rsv", ir, 1'b0, 1'b0, 1'b0, 0);
            tick;
        end else begin
            carry_in = 1'($urandom);
            expect_exec("mem_addr", ir, 1'b1, 1'b0, 1'b0, 0);
            tick;
            for (int b = 1; b < MEM_CYC; b++) begin
                n_stall = $urandom_range(0, max_stall);
                for (int k = 0; k < n_stall; k++) begin
                    mem_ready = 1'b0; carry_in = 1'($urandom); irq = 1'($urandom);
                    expect_exec("mem_stall", ir, 1'b0, 1'b1, 1'b0, b);
                    tick;
                end
                mem_ready = 1'b1; carry_in = 1'($urandom);
                expect_exec("mem_data", ir, 1'b0, 1'b1, 1'b0, b);
                tick;
            end
        end
        irq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst_in = '0; mem_ready = 1'b0; carry_in = 1'b0;
        tick; tick;
        rst = 1'b0;
        expect_idle("reset", 1'b0);

        // Directed: ALU with carry, then JMP taken/not-taken against the carry flag.
        run_instr(8'h05, 1, 0, 1'b0, 1, 0);
        expect_idle("after_alu", 1'b0);
        run_instr(8'hF0, 0, 0, 1'b0, 2, 0);
        run_instr(8'hE0, 0, 0, 1'b0, 2, 0);
        run_instr(8'h80, 0, 3, 1'b0, 2, 0);

        // Back-to-back ALU ops with inst_valid held high.
        run_instr(8'h13, 0, 0, 1'b1, 0, 0);
        run_instr(8'h2A, 0, 0, 1'b1, 1, 0);
        run_instr(8'h47, 0, 0, 1'b1, 0, 0);

        // Reset in the middle of a memory stall.
        run_instr(8'h01, 0, 0, 1'b0, 1, 0);
        inst_valid = 1'b1; inst_in = 8'h9C;
        expect_idle("rst_fetch", 1'b1);
        tick;
        inst_valid = 1'b0; mem_ready = 1'b0;
        expect_exec("rst_addr", 8'h9C, 1'b1, 1'b0, 1'b0, 0);
        tick;
        expect_exec("rst_stall", 8'h9C, 1'b0, 1'b1, 1'b0, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0; carry_m = 1'b0; ie_m = 1'b1;
        expect_idle("rst_mid", 1'b0);
        tick;
        expect_idle("rst_hold", 1'b0);

`ifdef CONTROL_SEQ_IRQ_EN
        // IRQ beats inst_valid; further irqs ignored until a JMP with RS all ones.
        run_instr(8'h11, 0, 0, 1'b0, 2, 100);
        run_instr(8'h22, 0, 0, 1'b0, 2, 100);
        run_instr(8'hE3, 0, 0, 1'b0, 2, 100);
        run_instr(8'h33, 0, 0, 1'b0, 2, 100);
        run_instr(8'hE3, 0, 0, 1'b0, 2, 0);
`endif

        for (int n = 0; n < 300; n++) begin
            run_instr(IW'($urandom), $urandom_range(0, 2), 3, 1'($urandom), 2, 25);
        end
        inst_valid = 1'b0;
        expect_idle("final", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
